sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
- Two-requester round-robin controller in front of one single-port RAM (sp_ram_model interface: A/DI/BW/CE/RDWEN/DO).
- After reset, optionally runs a zero-initialisation sweep of the whole RAM.
- Then time-multiplexes read and write requests from two clients, with one access per cycle.
- Returns read data to the requester that issued the read, with fixed 1-cycle latency.

Parameters:
- ADDR_WIDTH, 1: RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 1: RAM data width; also the width of the BW bit-write mask.
- INIT_EN, 1: 1 runs the post-reset zero sweep; 0 enters RUN directly after reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ0, REQ1  in  1  request valid, per client. Held until granted.
- RDWEN0, RDWEN1  in  1  1 = write, 0 = read.
- A0, A1  in  ADDR_WIDTH  request address.
- DI0, DI1  in  DATA_WIDTH  write data.
- BW0, BW1  in  DATA_WIDTH  per-bit write enable.
- GNT0, GNT1  out  1  grant. A request is accepted in the cycle where REQi & GNTi.
- RVALID0, RVALID1  out  1  read data valid for client i; a 1-cycle pulse.
- DO  out  DATA_WIDTH  read data (RAM DO passthrough). Valid only while some RVALIDi is high.
- INIT_DONE  out  1  high once the RUN state is reached.
- RAM_CE, RAM_RDWEN  out  1  to RAM CE / RDWEN.
- RAM_A  out  ADDR_WIDTH  to RAM A.
- RAM_DI, RAM_BW  out  DATA_WIDTH  to RAM DI / BW.
- RAM_DO  in  DATA_WIDTH  from RAM DO (registered inside the RAM, 1-cycle read latency).

Behaviour:
- While RST is high, at the following edge:
  - state <= INIT (INIT_EN=1) or RUN (INIT_EN=0).
  - init counter <= 0, priority pointer <= client 0, RVALID0/1 <= 0.
- While RST is high, GNT0/1, RAM_CE and INIT_DONE are forced to 0.
- Reset mid-sweep or mid-read: the sweep restarts from address 0 and any pending RVALID is dropped.
- INIT state:
  - RAM_CE=1, RAM_RDWEN=1, RAM_BW=all ones, RAM_DI=0, RAM_A=counter.
  - Counter increments each cycle.
  - When counter == DEPTH-1, that last write issues and the next state is RUN.
  - Sweep length is exactly DEPTH cycles; the counter never wraps (ADDR_WIDTH bits, terminal compare).
  - GNT0/1 = 0 throughout. Requests stay pending; they are not lost.
- RUN state: INIT_DONE=1 (registered, from the first RUN cycle).
- Arbitration (combinational, same cycle):
  - Only one requester: it is granted.
  - Both requesting: the client named by the priority pointer is granted.
  - After any grant, the pointer <= the non-granted client's index. Strict alternation under contention.
  - No request: the pointer holds.
  - At most one GNT high per cycle.
- RAM drive in RUN:
  - RAM_CE = any grant.
  - RAM_RDWEN/A/DI/BW are muxed from the granted client.
  - With no grant: RAM_CE=0, other RAM outputs 0.
- Read return:
  - A granted read (RDWEN=0) in cycle t sets RVALIDi=1 in cycle t+1 only; DO = RAM_DO in that cycle.
  - Back-to-back reads return in order, one per cycle. There is no response backpressure.
- Ordering: accesses are serialised in grant order. A write granted at t is visible to a read granted at t+1 or later.
- Write with BW=0 is a no-op write but still consumes the slot and the grant.

Decomposition:
- No shared package needed.
- State encoding localparams (ST_INIT, ST_RUN) are local to the module.
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter with a registered priority pointer. Inputs: req[1:0], advance. Output: one-hot gnt.

Test Plan:
- Init sweep (ADDR_WIDTH=4, DATA_WIDTH=8, INIT_EN=1), RST for 2 cycles, then release:
  - Expect RAM_CE=1, RAM_A=0..15 on 16 consecutive cycles, BW=0xFF, DI=0.
  - Expect INIT_DONE rising on the 17th cycle; GNT0/1 stay 0 even with REQ0 held.
- Single read:
  - After init, write 0xA5 to addr 3 via client 0, then read addr 3 via client 1.
  - Expect RVALID1=1 exactly one cycle after GNT1, DO=0xA5, RVALID0=0.
- Contention:
  - REQ0 and REQ1 both held high for 6 cycles, pointer starting at 0.
  - Expect GNT order 0,1,0,1,0,1; never both high.
- Bit mask:
  - Write 0xFF to addr 5, then write DI=0x00 with BW=0x0F, then read addr 5.
  - Expect DO=0xF0.
- Reset mid-operation:
  - Assert RST on sweep cycle 7: sweep restarts at address 0 and takes 16 full cycles.
  - Assert RST in the cycle after a read grant: no RVALID pulse appears.
- INIT_EN=0: first cycle after RST drops, INIT_DONE=1 and REQ0 is granted immediately.

Source files
------------

// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between the two clients, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the clients-plus-RAM side.
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
);
    logic                  REQ0, REQ1;
    logic                  RDWEN0, RDWEN1;
    logic [ADDR_WIDTH-1:0] A0, A1;
    logic [DATA_WIDTH-1:0] DI0, DI1;
    logic [DATA_WIDTH-1:0] BW0, BW1;
    logic                  GNT0, GNT1;
    logic                  RVALID0, RVALID1;
    logic [DATA_WIDTH-1:0] DO;
    logic                  INIT_DONE;
    logic                  RAM_CE, RAM_RDWEN;
    logic [ADDR_WIDTH-1:0] RAM_A;
    logic [DATA_WIDTH-1:0] RAM_DI, RAM_BW;
    logic [DATA_WIDTH-1:0] RAM_DO;

    modport slave (
        input  REQ0, REQ1, RDWEN0, RDWEN1, A0, A1, DI0, DI1, BW0, BW1, RAM_DO,
        output GNT0, GNT1, RVALID0, RVALID1, DO, INIT_DONE,
        output RAM_CE, RAM_RDWEN, RAM_A, RAM_DI, RAM_BW
    );

    modport master (
        output REQ0, REQ1, RDWEN0, RDWEN1, A0, A1, DI0, DI1, BW0, BW1, RAM_DO,
        input  GNT0, GNT1, RVALID0, RVALID1, DO, INIT_DONE,
        input  RAM_CE, RAM_RDWEN, RAM_A, RAM_DI, RAM_BW
    );
endinterface

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, registered
// priority pointer that moves to the losing client after every grant.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
    end

    // Granting client 0 hands priority to client 1 and vice versa.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end
endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin front end for a single-port RAM: optional zero sweep after
// reset, then one client access per cycle with 1-cycle read return.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter bit INIT_EN    = 1'b1
) (
    input logic              CLK,
    input logic              RST,
    sp_ram_arbiter_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  run;
    logic [1:0]            req, gnt;
    logic [1:0]            rvld_p1;
    logic                  ram_ce, ram_rdwen;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [DATA_WIDTH-1:0] ram_di, ram_bw;

    assign run = (state_q == ST_RUN) && !RST;
    assign req = {bus.REQ1, bus.REQ0} & {2{run}};

    rr_arb2 u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .advance (|req),
        .gnt     (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_ce    = 1'b0;
        ram_rdwen = 1'b0;
        ram_a     = '0;
        ram_di    = '0;
        ram_bw    = '0;
        case (state_q)
            ST_INIT: begin
                ram_ce    = 1'b1;
                ram_rdwen = 1'b1;
                ram_bw    = '1;
                ram_a     = cnt_q;
                // Terminal compare: the counter stops on the last address.
                if (cnt_q == CNT_LAST) state_d = ST_RUN;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: begin
                ram_ce = |gnt;
                if (gnt[0]) begin
                    ram_rdwen = bus.RDWEN0;
                    ram_a     = bus.A0;
                    ram_di    = bus.DI0;
                    ram_bw    = bus.BW0;
                end else if (gnt[1]) begin
                    ram_rdwen = bus.RDWEN1;
                    ram_a     = bus.A1;
                    ram_di    = bus.DI1;
                    ram_bw    = bus.BW1;
                end
            end
        endcase
        if (RST) ram_ce = 1'b0;
    end

    // Stage p0 -> p1: a read granted now returns its data next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            rvld_p1 <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rvld_p1 <= gnt & ~{bus.RDWEN1, bus.RDWEN0};
        end
    end

    assign bus.GNT0      = gnt[0];
    assign bus.GNT1      = gnt[1];
    assign bus.RVALID0   = rvld_p1[0] && !RST;
    assign bus.RVALID1   = rvld_p1[1] && !RST;
    assign bus.DO        = bus.RAM_DO;
    assign bus.INIT_DONE = run;
    assign bus.RAM_CE    = ram_ce;
    assign bus.RAM_RDWEN = ram_rdwen;
    assign bus.RAM_A     = ram_a;
    assign bus.RAM_DI    = ram_di;
    assign bus.RAM_BW    = ram_bw;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: behavioural RAM, reference memory and
// round-robin model, directed scenarios plus a randomized two-client run.
module tb_sp_ram_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic CLK    = 1'b0;
    logic RST    = 1'b1;
    logic RST_NI = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_ptr     = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ram     [DEPTH];

    always #5 CLK = ~CLK;

    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_ni ();

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave));
    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b0)) dut_ni (
        .CLK(CLK), .RST(RST_NI), .bus(bus_ni.slave));

    // Single-port RAM with registered read data
    always @(posedge CLK) begin
        if (bus.RAM_CE) begin
            if (bus.RAM_RDWEN)
                ram[bus.RAM_A] <= (ram[bus.RAM_A] & ~bus.RAM_BW) | (bus.RAM_DI & bus.RAM_BW);
            else
                bus.RAM_DO <= ram[bus.RAM_A];
        end
    end
    assign bus_ni.RAM_DO = '0;

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int c, input logic rq, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] bw);
        if (c == 0) begin
            bus.REQ0 = rq; bus.RDWEN0 = wr; bus.A0 = a; bus.DI0 = d; bus.BW0 = bw;
        end else begin
            bus.REQ1 = rq; bus.RDWEN1 = wr; bus.A1 = a; bus.DI1 = d; bus.BW1 = bw;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Issues one request, waits (bounded) for its grant, returns the
    // RVALID/DO seen in the following cycle, and updates the model.
    task automatic access(input int c, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] bw,
                          output logic granted, output logic rv0, output logic rv1,
                          output logic [DW-1:0] dout);
        granted = 1'b0;
        drive(c, 1'b1, wr, a, d, bw);
        for (int i = 0; i < 4 && !granted; i++) begin
            #1;
            granted = (c == 0) ? bus.GNT0 : bus.GNT1;
            nxt();
        end
        drive(c, 1'b0, 1'b0, '0, '0, '0);
        #1;
        rv0  = bus.RVALID0;
        rv1  = bus.RVALID1;
        dout = bus.DO;
        if (granted) begin
            if (wr) ref_mem[a] = (ref_mem[a] & ~bw) | (d & bw);
            exp_ptr = 1 - c;
        end
        nxt();
    endtask

    task automatic test_reset();
        idle();
        drive(0, 1'b1, 1'b0, '0, '0, '0);
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nxt();
            vectors++;
            if (bus.GNT0 !== 1'b0 || bus.GNT1 !== 1'b0 || bus.RAM_CE !== 1'b0 ||
                bus.INIT_DONE !== 1'b0 || bus.RVALID0 !== 1'b0 || bus.RVALID1 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: GNT=%b%b CE=%b DONE=%b RV=%b%b, need all 0",
                         i, bus.GNT1, bus.GNT0, bus.RAM_CE, bus.INIT_DONE, bus.RVALID1, bus.RVALID0);
            end
        end
    endtask

    task automatic test_init_sweep();
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            vectors++;
            if (bus.RAM_CE !== 1'b1 || bus.RAM_RDWEN !== 1'b1 || bus.RAM_A !== AW'(i) ||
                bus.RAM_BW !== 8'hFF || bus.RAM_DI !== 8'h00 || bus.GNT0 !== 1'b0 ||
                bus.GNT1 !== 1'b0 || bus.INIT_DONE !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep cyc%0d: CE=%b WE=%b A=%0d BW=%h DI=%h GNT=%b%b DONE=%b, need 1 1 %0d ff 00 00 0",
                         i, bus.RAM_CE, bus.RAM_RDWEN, bus.RAM_A, bus.RAM_BW, bus.RAM_DI,
                         bus.GNT1, bus.GNT0, bus.INIT_DONE, i);
            end
            nxt();
        end
        clear_ref();
        #1;
        vectors++;
        if (bus.INIT_DONE !== 1'b1 || bus.GNT0 !== 1'b1 || bus.GNT1 !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_done: DONE=%b GNT=%b%b, need 1 01", bus.INIT_DONE, bus.GNT1, bus.GNT0);
        end
        exp_ptr = 1;
        nxt();
        idle();
        #1;
        vectors++;
        if (bus.RVALID0 !== 1'b1 || bus.RVALID1 !== 1'b0 || bus.DO !== 8'h00) begin
            miscompares++;
            $display("FAIL held_read: RV=%b%b DO=%h, need 01 00", bus.RVALID1, bus.RVALID0, bus.DO);
        end
        nxt();
    endtask

    task automatic test_single_read();
        logic gr, rv0, rv1;
        logic [DW-1:0] dout;
        access(0, 1'b1, 4'd3, 8'hA5, 8'hFF, gr, rv0, rv1, dout);
        vectors++;
        if (gr !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_grant: granted=%b, need 1", gr);
        end
        access(1, 1'b0, 4'd3, 8'h00, 8'h00, gr, rv0, rv1, dout);
        vectors++;
        if (gr !== 1'b1 || rv1 !== 1'b1 || rv0 !== 1'b0 || dout !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_read: gnt=%b RV=%b%b DO=%h, need 1 10 a5", gr, rv1, rv0, dout);
        end
        #1;
        vectors++;
        if (bus.RVALID1 !== 1'b0 || bus.RVALID0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rvalid_pulse: RV=%b%b two cycles after grant, need 00", bus.RVALID1, bus.RVALID0);
        end
    endtask

    task automatic test_contention();
        idle();
        drive(0, 1'b1, 1'b1, 4'd9, 8'h11, 8'h00);
        drive(1, 1'b1, 1'b1, 4'd9, 8'h22, 8'h00);
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (bus.GNT0 !== (i % 2 == 0) || bus.GNT1 !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL contention cyc%0d: GNT=%b%b, need client %0d only",
                         i, bus.GNT1, bus.GNT0, i % 2);
            end
            nxt();
        end
        exp_ptr = 0;
        idle();
        nxt();
    endtask

    task automatic test_bitmask();
        logic gr, rv0, rv1;
        logic [DW-1:0] dout;
        access(0, 1'b1, 4'd5, 8'hFF, 8'hFF, gr, rv0, rv1, dout);
        access(1, 1'b1, 4'd5, 8'h00, 8'h0F, gr, rv0, rv1, dout);
        access(0, 1'b0, 4'd5, 8'h00, 8'h00, gr, rv0, rv1, dout);
        vectors++;
        if (rv0 !== 1'b1 || dout !== 8'hF0) begin
            miscompares++;
            $display("FAIL bitmask: RV0=%b DO=%h, need 1 f0", rv0, dout);
        end
        access(1, 1'b1, 4'd5, 8'h0F, 8'h00, gr, rv0, rv1, dout);
        access(1, 1'b0, 4'd5, 8'h00, 8'h00, gr, rv0, rv1, dout);
        vectors++;
        if (gr !== 1'b1 || rv1 !== 1'b1 || dout !== 8'hF0) begin
            miscompares++;
            $display("FAIL bw_zero_write: gnt=%b RV1=%b DO=%h, need 1 1 f0", gr, rv1, dout);
        end
    endtask

    task automatic test_random();
        logic          pend [2];
        logic          wr   [2];
        logic [AW-1:0] a    [2];
        logic [DW-1:0] d    [2];
        logic [DW-1:0] bw   [2];
        logic          erv  [2];
        logic [DW-1:0] edo;
        int            g;
        pend = '{1'b0, 1'b0};
        erv  = '{1'b0, 1'b0};
        wr   = '{1'b0, 1'b0};
        a    = '{'0, '0};
        d    = '{'0, '0};
        bw   = '{'0, '0};
        edo  = '0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && $urandom_range(0, 2) != 0) begin
                    pend[c] = 1'b1;
                    wr[c]   = 1'($urandom_range(0, 1));
                    a[c]    = AW'($urandom_range(0, 5));
                    d[c]    = DW'($urandom);
                    bw[c]   = ($urandom_range(0, 3) == 0) ? DW'($urandom) : 8'hFF;
                end
                drive(c, pend[c], wr[c], a[c], d[c], bw[c]);
            end
            #1;
            g = -1;
            if (pend[0] && pend[1]) g = exp_ptr;
            else if (pend[0])       g = 0;
            else if (pend[1])       g = 1;
            vectors++;
            if (bus.GNT0 !== (g == 0) || bus.GNT1 !== (g == 1) || bus.RAM_CE !== (g >= 0)) begin
                miscompares++;
                $display("FAIL rand_gnt n=%0d: GNT=%b%b CE=%b, need client %0d", n,
                         bus.GNT1, bus.GNT0, bus.RAM_CE, g);
            end
            if (g >= 0) begin
                vectors++;
                if (bus.RAM_A !== a[g] || bus.RAM_RDWEN !== wr[g]) begin
                    miscompares++;
                    $display("FAIL rand_ram n=%0d: A=%0d WE=%b, need %0d %b", n,
                             bus.RAM_A, bus.RAM_RDWEN, a[g], wr[g]);
                end
            end
            vectors++;
            if (bus.RVALID0 !== erv[0] || bus.RVALID1 !== erv[1] ||
                ((erv[0] || erv[1]) && bus.DO !== edo)) begin
                miscompares++;
                $display("FAIL rand_rdata n=%0d: RV=%b%b DO=%h, need %b%b %h", n,
                         bus.RVALID1, bus.RVALID0, bus.DO, erv[1], erv[0], edo);
            end
            erv = '{1'b0, 1'b0};
            if (g >= 0) begin
                if (wr[g]) ref_mem[a[g]] = (ref_mem[a[g]] & ~bw[g]) | (d[g] & bw[g]);
                else begin
                    erv[g] = 1'b1;
                    edo    = ref_mem[a[g]];
                end
                pend[g] = 1'b0;
                exp_ptr = 1 - g;
            end
            nxt();
        end
        idle();
        nxt();
    endtask

    task automatic test_reset_mid();
        idle();
        drive(0, 1'b1, 1'b0, 4'd3, '0, '0);
        #1;
        vectors++;
        if (bus.GNT0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_read_grant: GNT0=%b, need 1", bus.GNT0);
        end
        nxt();
        idle();
        RST = 1'b1;
        #1;
        vectors++;
        if (bus.RVALID0 !== 1'b0 || bus.RVALID1 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drop_rvalid: RV=%b%b, need 00", bus.RVALID1, bus.RVALID0);
        end
        nxt();
        RST = 1'b0;
        for (int i = 0; i < 7; i++) nxt();
        #1;
        vectors++;
        if (bus.RAM_A !== 4'd7 || bus.RAM_CE !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_cyc7: A=%0d CE=%b, need 7 1", bus.RAM_A, bus.RAM_CE);
        end
        RST = 1'b1;
        nxt();
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            vectors++;
            if (bus.RAM_CE !== 1'b1 || bus.RAM_A !== AW'(i) || bus.INIT_DONE !== 1'b0) begin
                miscompares++;
                $display("FAIL resweep cyc%0d: CE=%b A=%0d DONE=%b, need 1 %0d 0",
                         i, bus.RAM_CE, bus.RAM_A, bus.INIT_DONE, i);
            end
            nxt();
        end
        #1;
        vectors++;
        if (bus.INIT_DONE !== 1'b1) begin
            miscompares++;
            $display("FAIL resweep_done: DONE=%b, need 1", bus.INIT_DONE);
        end
        clear_ref();
        exp_ptr = 0;
        nxt();
    endtask

    task automatic test_init_en0();
        RST_NI = 1'b1;
        bus_ni.REQ0 = 1'b1; bus_ni.RDWEN0 = 1'b1; bus_ni.A0 = 4'd2;
        bus_ni.DI0 = 8'h5A; bus_ni.BW0 = 8'hFF;
        nxt();
        vectors++;
        if (bus_ni.GNT0 !== 1'b0 || bus_ni.INIT_DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL ni_reset: GNT0=%b DONE=%b, need 0 0", bus_ni.GNT0, bus_ni.INIT_DONE);
        end
        nxt();
        RST_NI = 1'b0;
        #1;
        vectors++;
        if (bus_ni.INIT_DONE !== 1'b1 || bus_ni.GNT0 !== 1'b1 || bus_ni.RAM_CE !== 1'b1 ||
            bus_ni.RAM_A !== 4'd2 || bus_ni.RAM_DI !== 8'h5A) begin
            miscompares++;
            $display("FAIL ni_first_cycle: DONE=%b GNT0=%b CE=%b A=%0d DI=%h, need 1 1 1 2 5a",
                     bus_ni.INIT_DONE, bus_ni.GNT0, bus_ni.RAM_CE, bus_ni.RAM_A, bus_ni.RAM_DI);
        end
        nxt();
        bus_ni.REQ0 = 1'b0;
        nxt();
    endtask

    initial begin
        bus_ni.REQ0 = 1'b0; bus_ni.REQ1 = 1'b0; bus_ni.RDWEN0 = 1'b0; bus_ni.RDWEN1 = 1'b0;
        bus_ni.A0 = '0; bus_ni.A1 = '0; bus_ni.DI0 = '0; bus_ni.DI1 = '0;
        bus_ni.BW0 = '0; bus_ni.BW1 = '0;
        clear_ref();
        idle();
        #1;
        test_reset();
        test_init_sweep();
        test_single_read();
        test_contention();
        test_bitmask();
        test_random();
        test_reset_mid();
        test_init_en0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
